// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory slave with a valid/ready request
// channel and a valid/ready response channel. Requests are served from an
// internal word array. Each response is returned after either a fixed delay
// or a pseudo-random delay taken from an 8-bit LFSR.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter bit          RAND_EN     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned LAT_W      = $clog2(LATENCY + 1);
  localparam int unsigned CNT_W      = (LAT_W > 4) ? LAT_W : 4;
  // Byte span of the array; kept 33 bits wide so a full 4 GiB span cannot overflow.
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] delay;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             lfsr_fb;
  logic             wen_q, wen_d;
  logic             err_q, err_d;
  logic [31:0]      rd_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic [31:0]      offset;
  logic             addr_err;
  logic [IDX_W-1:0] index;

  // An accept is blocked while reset is held, so no array write can slip in during reset.
  assign accept   = req_valid && (state_q == IDLE) && !rst;
  // Offset wraps modulo 2^32; an address below the base fails the first term.
  assign offset   = req_addr - BASE_ADDR;
  assign addr_err = (req_addr < BASE_ADDR) || ({1'b0, offset} >= SPAN_BYTES);
  assign index    = offset[IDX_W+1:2];
  // Taps for x^8 + x^6 + x^5 + x^4 + 1.
  assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Select the delay for the next transaction: fixed, or 1..8 from the LFSR.
  always_comb begin
    if (RAND_EN) begin
      delay = CNT_W'({1'b0, lfsr_q[2:0]}) + CNT_W'(1);
    end else begin
      delay = CNT_W'(LATENCY);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transaction bookkeeping registers: delay counter, LFSR and latched flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      lfsr_q <= 8'hA5;
      wen_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
      wen_q  <= wen_d;
      err_q  <= err_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, wait for the handshake in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    wen_d   = wen_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wen_d   = req_wen;
          err_d   = addr_err;
          cnt_d   = delay - CNT_W'(1);
          lfsr_d  = {lfsr_q[6:0], lfsr_fb};
          state_d = (delay > CNT_W'(1)) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // The decrement reaching zero is the last waiting cycle.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Array port: byte-masked write and read snapshot, both taken on the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (req_wen && !addr_err) begin
        for (int b = 0; b < 4; b++) begin
          if (req_wmask[b]) begin
            mem[index][8*b +: 8] <= req_wdata[8*b +: 8];
          end
        end
      end
      rd_q <= mem[index];
    end
  end

  // Output decode: the snapshot is only shown for a good read in RESP.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_err   = (state_q == RESP) && err_q;
    resp_rdata = ((state_q == RESP) && !wen_q && !err_q) ? rd_q : 32'h0;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder. Instance A uses a fixed delay of 2 with directed
// transactions and literal expected values. Instance B uses random delays on
// a 16-word array. It receives random traffic, and a monitor compares every
// cycle of B against a word-array model.
module tb_mem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h", name, got, exp);
    end
  endtask

  // ---------------- instance A: fixed latency 2, 4096 words
  logic        a_rst = 1'b1, a_req_valid = 1'b0, a_req_wen = 1'b0, a_resp_ready = 1'b1;
  logic [31:0] a_req_addr = '0, a_req_wdata = '0;
  logic [3:0]  a_req_wmask = '0;
  logic        a_req_ready, a_resp_valid, a_resp_err;
  logic [31:0] a_resp_rdata;

  mem_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(BASE), .LATENCY(2), .RAND_EN(1'b0)) dut_a (
    .clk(clk), .rst(a_rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wen(a_req_wen),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wmask(a_req_wmask),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  // ---------------- instance B: random latency, 16 words
  logic        b_rst = 1'b1, b_req_valid = 1'b0, b_req_wen = 1'b0, b_resp_ready = 1'b1;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic [3:0]  b_req_wmask = '0;
  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;

  mem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(BASE), .LATENCY(2), .RAND_EN(1'b1)) dut_b (
    .clk(clk), .rst(b_rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  // One A transaction. The request is driven at a negedge. dly counts negedges
  // from the accept sample to the first resp_valid sample. hold > 0 keeps
  // resp_ready low for that many extra cycles, and the outputs are checked
  // for stability during that time.
  task automatic a_xact(input string nm, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask, input int hold,
                        output logic [31:0] rd, output logic er, output int dly);
    @(negedge clk);
    chk({nm, "_ready_before"}, a_req_ready, 1);
    a_req_valid  = 1'b1;
    a_req_wen    = wen;
    a_req_addr   = addr;
    a_req_wdata  = wdata;
    a_req_wmask  = wmask;
    a_resp_ready = (hold == 0);
    @(negedge clk);
    a_req_valid = 1'b0;
    dly = 1;
    while (!a_resp_valid && dly < 20) begin
      @(negedge clk);
      dly++;
    end
    rd = a_resp_rdata;
    er = a_resp_err;
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk({nm, "_hold_valid"}, a_resp_valid, 1);
        chk({nm, "_hold_rdata"}, a_resp_rdata, rd);
        chk({nm, "_hold_ready"}, a_req_ready, 0);
      end
      a_resp_ready = 1'b1;
      @(negedge clk);
      chk({nm, "_post_valid"}, a_resp_valid, 0);
      chk({nm, "_post_ready"}, a_req_ready, 1);
    end
  endtask

  task automatic a_expect(input string nm, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask, input int hold,
                          input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    int          dly;
    a_xact(nm, wen, addr, wdata, wmask, hold, rd, er, dly);
    chk({nm, "_delay"}, dly, 2);
    chk({nm, "_rdata"}, rd, exp_rd);
    chk({nm, "_err"}, er, exp_er);
    $display("A %s wen=%0d addr=%08h wdata=%08h wmask=%h -> rdata=%08h err=%0d delay=%0d",
             nm, wen, addr, wdata, wmask, rd, er, dly);
  endtask

  // ---------------- B model and per-cycle monitor
  logic [31:0] bmem [16];
  logic [31:0] exp_rd_q [$];
  logic        exp_er_q [$];
  logic        b_busy = 1'b0, b_seen = 1'b0;
  int          b_k = 0;
  logic        prev_v = 1'b0, prev_r = 1'b0, prev_e = 1'b0;
  logic [31:0] prev_d = '0;

  always @(negedge clk) begin
    if (b_rst) begin
      chk("b_rst_valid", b_resp_valid, 0);
      chk("b_rst_ready", b_req_ready, 1);
      chk("b_rst_rdata", b_resp_rdata, 0);
      exp_rd_q.delete();
      exp_er_q.delete();
      b_busy = 1'b0;
      b_seen = 1'b0;
      prev_v = 1'b0;
    end else begin
      chk("b_req_ready", b_req_ready, !b_busy);
      if (!b_busy) chk("b_idle_valid", b_resp_valid, 0);
      if (b_busy && !b_seen) begin
        b_k++;
        if (b_resp_valid) begin
          b_seen = 1'b1;
          chk("b_delay_range", (b_k >= 1 && b_k <= 8), 1);
        end else if (b_k > 20) begin
          chk("b_resp_timeout", 0, 1);
          b_busy = 1'b0;
        end
      end
      if (b_resp_valid && prev_v && !prev_r) begin
        chk("b_stable_rdata", b_resp_rdata, prev_d);
        chk("b_stable_err", b_resp_err, prev_e);
      end
      if (b_resp_valid && b_resp_ready && b_busy && exp_rd_q.size() > 0) begin
        chk("b_rdata", b_resp_rdata, exp_rd_q.pop_front());
        chk("b_err", b_resp_err, exp_er_q.pop_front());
        $display("B resp rdata=%08h err=%0d delay=%0d", b_resp_rdata, b_resp_err, b_k);
        b_busy = 1'b0;
      end
      if (b_req_valid && b_req_ready) begin
        logic [31:0] off;
        logic        er;
        off = b_req_addr - BASE;
        er  = (b_req_addr < BASE) || (off >= 32'd64);
        if (er) begin
          exp_rd_q.push_back(32'h0);
          exp_er_q.push_back(1'b1);
        end else if (b_req_wen) begin
          for (int b = 0; b < 4; b++)
            if (b_req_wmask[b]) bmem[off >> 2][8*b +: 8] = b_req_wdata[8*b +: 8];
          exp_rd_q.push_back(32'h0);
          exp_er_q.push_back(1'b0);
        end else begin
          exp_rd_q.push_back(bmem[off >> 2]);
          exp_er_q.push_back(1'b0);
        end
        b_busy = 1'b1;
        b_seen = 1'b0;
        b_k    = 0;
      end
      prev_v = b_resp_valid;
      prev_r = b_resp_ready;
      prev_d = b_resp_rdata;
      prev_e = b_resp_err;
    end
  end

  // The first 16 accepted requests write every word so the model starts fully known.
  task automatic b_gen(input int n);
    int r;
    if (n < 16) begin
      b_req_wen   = 1'b1;
      b_req_addr  = BASE + 32'(4 * n);
      b_req_wdata = $urandom;
      b_req_wmask = 4'hF;
    end else begin
      r = $urandom_range(0, 19);
      b_req_wen   = 1'($urandom_range(0, 1));
      b_req_addr  = (r == 19) ? BASE - 32'd4 : BASE + 32'(4 * r) + 32'($urandom_range(0, 3));
      b_req_wdata = $urandom;
      b_req_wmask = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          dly, n, cyc;
    logic        rdy_prev, reset_done;

    // ---------- A: reset values
    repeat (2) @(negedge clk);
    chk("a_rst_ready", a_req_ready, 1);
    chk("a_rst_valid", a_resp_valid, 0);
    a_rst = 1'b0;
    @(negedge clk);
    chk("a_idle_ready", a_req_ready, 1);
    chk("a_idle_valid", a_resp_valid, 0);
    chk("a_idle_rdata", a_resp_rdata, 0);
    chk("a_idle_err", a_resp_err, 0);

    // ---------- A: write, read, byte mask
    a_expect("wr_full", 1, 32'h8000_0010, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0);
    a_expect("rd_full", 0, 32'h8000_0010, 32'h0, 4'h0, 0, 32'hDEADBEEF, 0);
    a_expect("wr_mask", 1, 32'h8000_0010, 32'h11223344, 4'b0101, 0, 32'h0, 0);
    a_expect("rd_mask", 0, 32'h8000_0010, 32'h0, 4'h0, 0, 32'hDE22BE44, 0);
    a_expect("wr_nomask", 1, 32'h8000_0010, 32'hFFFFFFFF, 4'h0, 0, 32'h0, 0);
    a_expect("rd_nomask", 0, 32'h8000_0010, 32'h0, 4'h0, 0, 32'hDE22BE44, 0);

    // ---------- A: range boundaries
    a_expect("wr_word0", 1, 32'h8000_0000, 32'h0BADF00D, 4'hF, 0, 32'h0, 0);
    a_expect("wr_last", 1, 32'h8000_3FFC, 32'hCAFEF00D, 4'hF, 0, 32'h0, 0);
    a_expect("rd_below", 0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, 32'h0, 1);
    a_expect("wr_above", 1, 32'h8000_4000, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1);
    a_expect("rd_word0", 0, 32'h8000_0000, 32'h0, 4'h0, 0, 32'h0BADF00D, 0);
    a_expect("rd_last", 0, 32'h8000_3FFF, 32'h0, 4'h0, 0, 32'hCAFEF00D, 0);

    // ---------- A: backpressure for 5 cycles
    a_expect("rd_bp", 0, 32'h8000_0010, 32'h0, 4'h0, 5, 32'hDE22BE44, 0);

    // ---------- A: asynchronous reset while a response is pending
    a_xact("rd_arst", 0, 32'h8000_0000, 32'h0, 4'h0, 0, rd, er, dly);
    chk("rd_arst_rdata", rd, 32'h0BADF00D);
    a_resp_ready = 1'b0;
    @(negedge clk);
    a_req_valid = 1'b1;
    a_req_wen   = 1'b0;
    a_req_addr  = 32'h8000_0010;
    @(negedge clk);
    a_req_valid = 1'b0;
    dly = 1;
    while (!a_resp_valid && dly < 20) begin
      @(negedge clk);
      dly++;
    end
    chk("arst_pending_valid", a_resp_valid, 1);
    #2 a_rst = 1'b1;
    #1;
    chk("arst_ready", a_req_ready, 1);
    chk("arst_valid", a_resp_valid, 0);
    chk("arst_rdata", a_resp_rdata, 0);
    chk("arst_err", a_resp_err, 0);
    $display("A async reset mid-cycle: ready=%0d valid=%0d", a_req_ready, a_resp_valid);
    @(negedge clk);
    a_rst = 1'b0;
    a_resp_ready = 1'b1;
    @(negedge clk);
    chk("arst_after_valid", a_resp_valid, 0);
    a_expect("rd_after_rst", 0, 32'h8000_0010, 32'h0, 4'h0, 0, 32'hDE22BE44, 0);

    // ---------- B: random traffic with random resp_ready and one reset during WAIT
    @(posedge clk);
    #2 b_rst = 1'b0;
    n = 0;
    cyc = 0;
    rdy_prev = 1'b0;
    reset_done = 1'b0;
    while (n < 200 && cyc < 20000) begin
      @(posedge clk);
      #2;
      cyc++;
      if (b_req_valid && rdy_prev) begin
        n++;
        b_req_valid = 1'b0;
      end
      if (!reset_done && n >= 100 && !b_req_ready && !b_resp_valid) begin
        b_rst = 1'b1;
        $display("B reset injected during WAIT after %0d accepts", n);
        @(posedge clk);
        #2 b_rst = 1'b0;
        reset_done = 1'b1;
        b_req_valid = 1'b0;
        rdy_prev = 1'b0;
      end else begin
        b_resp_ready = ($urandom_range(0, 3) != 0);
        if (b_req_ready) begin
          if (!b_req_valid && $urandom_range(0, 1) == 1) begin
            b_gen(n);
            b_req_valid = 1'b1;
          end
        end else begin
          b_gen(n);
          b_req_valid = 1'($urandom_range(0, 1));
        end
        rdy_prev = b_req_ready;
      end
    end
    b_req_valid  = 1'b0;
    b_resp_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;
    chk("b_accept_count", n, 200);
    chk("b_reset_injected", reset_done, 1);
    chk("b_drained_busy", b_busy, 0);
    chk("b_drained_queue", exp_rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the NPC core's valid/ready memory request interface, i.e. the slave answering IFU fetches and WBU loads/stores.
- Accepts one request at a time, performs a byte-masked word write or a word read on an internal word array, and returns a response after a fixed or pseudo-random delay.
- Used in simulation top-levels in place of DPI memory.
- Exercises the requesters' handshake stalls.

Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words in the array. Power of two.
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- LATENCY, 2: fixed accept-to-response delay in cycles. Minimum 1.
- RAND_EN, 0: 1 selects the LFSR-driven delay instead of LATENCY.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  32  byte address; bits [1:0] ignored
- req_wdata  in  32  write data
- req_wmask  in  4  byte enables; bit i enables byte i of the word
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts the response
- resp_rdata  out  32  read data; 0 for writes and errors
- resp_err  out  1  address out of range

Behaviour:
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, LFSR=8'hA5, delay counter=0.
  - Array contents are not reset.
  - Reset asserted mid-transaction aborts it. Any pending response is dropped; a write already accepted stays committed.
- States:
  - IDLE: req_ready=1. On req_valid&req_ready (accept):
    - latch wen, error flag and read snapshot;
    - load counter = delay-1;
    - go to WAIT if delay>1, else RESP.
  - WAIT: req_ready=0. Counter decrements each cycle; at 0, go to RESP.
  - RESP: resp_valid=1; resp_rdata and resp_err held stable until the handshake.
    - On resp_valid&resp_ready: go to IDLE and clear resp_valid.
    - Next accept is no earlier than the following cycle.
- Exactly one outstanding transaction. No request is accepted in WAIT or RESP.
- Delay:
  - RAND_EN=0: delay=LATENCY. Accept at edge T gives resp_valid high in the cycle after edge T+LATENCY-1, i.e. LATENCY=1 means resp_valid the cycle right after accept.
  - RAND_EN=1: delay=1+LFSR[2:0] (range 1..8).
  - LFSR: x^8+x^6+x^5+x^4+1, shifts once per accept.
- Address decode:
  - index=(req_addr-BASE_ADDR)>>2.
  - Error when req_addr<BASE_ADDR or index>=DEPTH_WORDS; the subtraction wraps modulo 2^32 and the compare is unsigned.
  - On error: no array write, resp_rdata=0, resp_err=1.
- Write:
  - Committed on the accept edge. Only bytes with wmask=1 change.
  - wmask=0 is a legal no-op write that still produces a response.
  - resp_rdata=0 for writes.
- Read: data captured on the accept edge, so a later write cannot alter an in-flight read response.
- resp_ready held low: RESP persists indefinitely; outputs stable.
- resp_ready high before resp_valid: ignored; there is no response without resp_valid.
- Requester deasserting req_valid while req_ready=0: no effect.

Test Plan:
- Reset then idle: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. Assert rst asynchronously mid-cycle: outputs return to these values immediately.
- LATENCY=2. Write 0x8000_0010, wdata=0xDEADBEEF, wmask=4'hF. Then read the same address → resp_valid exactly 2 cycles after each accept; read resp_rdata=0xDEADBEEF, resp_err=0.
- Byte mask: after the above, write 0x8000_0010, wdata=0x11223344, wmask=4'b0101 → read returns 0xDE22BE44.
- Out of range: read 0x7FFF_FFFC, then write 0x8000_0000+4*DEPTH_WORDS → both resp_err=1, resp_rdata=0; word 0 and the last word are unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles during RESP → resp_valid and resp_rdata stable, req_ready=0. Raise resp_ready → handshake, then req_ready=1 the next cycle.
- RAND_EN=1, 200 random reads and writes with random resp_ready → every delay in 1..8, response order matches request order, contents match a scoreboard model. A reset injected during WAIT yields no spurious resp_valid.
